// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA character display chain.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned CELL_W   = 8;
  localparam int unsigned CELL_H   = 16;

  localparam int unsigned COUNT_W  = 10;  // hCount / vCount width
  localparam int unsigned CODE_W   = 3;   // glyph code width
  localparam int unsigned ROW_W    = 4;   // glyph row width (log2 CELL_H)
  localparam int unsigned PIX_W    = 8;   // pixels per ROM byte (CELL_W)

  // Cell phases (hCount[2:0]) at which the fetch and the shifter load happen
  localparam logic [2:0] FETCH_PHASE = 3'd6;
  localparam logic [2:0] LOAD_PHASE  = 3'd7;

  typedef logic [CODE_W-1:0] glyphCode_t;
  typedef logic [ROW_W-1:0]  glyphRow_t;

  // Travels one cycle behind the fetch, alongside the ROM read
  typedef struct packed {
    logic valid;  // a real fetch happened (not one swallowed by reset)
    logic blank;  // charCode[2] of that fetch
  } fetchTag_t;

  // Glyph row of the pixel two positions ahead; wraps to the next line's row
  // when that pixel lies past the end of the current line.
  function automatic glyphRow_t fetchRow(input logic [COUNT_W-1:0] hCount,
                                         input glyphRow_t vRow,
                                         input int unsigned hTotal);
    if (32'(hCount) + 32'd2 >= hTotal) begin
      return vRow + 4'd1;
    end
    return vRow;
  endfunction

endpackage

// File: rtl/char_pixel_serializer_if.sv
// Video timing, character ROM and pixel signals of the serializer.
interface char_pixel_serializer_if;
  import vga_pkg::*;

  logic               videoOn;
  logic [COUNT_W-1:0] hCount;
  logic [COUNT_W-1:0] vCount;
  glyphCode_t         charCode;
  glyphCode_t         highAddrOffset;
  glyphRow_t          lowAddrOffset;
  logic               romEnable;
  logic [PIX_W-1:0]   romByte;
  logic               pixelOut;

  // Serializer side
  modport master (
    input  videoOn, hCount, vCount, charCode, romByte,
    output highAddrOffset, lowAddrOffset, romEnable, pixelOut
  );

  // Timing generator / ROM / display side
  modport slave (
    output videoOn, hCount, vCount, charCode, romByte,
    input  highAddrOffset, lowAddrOffset, romEnable, pixelOut
  );

endinterface

// File: rtl/pixel_shifter.sv
// 8-bit MSB-first pixel shift register: parallel load or shift left with zero fill.
module pixel_shifter
  import vga_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [PIX_W-1:0] loadData,
  output logic             pixelBit
);

  logic [PIX_W-1:0] shiftQ;

  // Load a new glyph byte at the cell boundary, otherwise advance one pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shiftQ <= '0;
    end else if (load) begin
      shiftQ <= loadData;
    end else begin
      shiftQ <= {shiftQ[PIX_W-2:0], 1'b0};
    end
  end

  assign pixelBit = shiftQ[PIX_W-1];

endmodule

// File: rtl/char_pixel_serializer.sv
// Character cell serializer: fetches one glyph row per cell from the character
// ROM two cycles ahead of display and shifts it out one pixel per clock.
module char_pixel_serializer #(
  parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE
) (
  input logic                     clock,
  input logic                     reset,
  char_pixel_serializer_if.master bus
);
  import vga_pkg::*;

  if (H_TOTAL % CELL_W != 0 || H_ACTIVE > H_TOTAL) begin : gen_bad_params
    $error("char_pixel_serializer: H_TOTAL must be a multiple of 8 and >= H_ACTIVE");
  end

  logic       fetch;
  logic       load;
  glyphRow_t  nextRow;
  glyphCode_t highQ;
  glyphRow_t  lowQ;
  fetchTag_t  tagQ;
  logic [PIX_W-1:0] loadData;
  logic       shiftBit;
  logic       unusedVcount;

  assign fetch   = (bus.hCount[2:0] == FETCH_PHASE);
  assign load    = (bus.hCount[2:0] == LOAD_PHASE);
  assign nextRow = fetchRow(bus.hCount, bus.vCount[ROW_W-1:0], H_TOTAL);

  // Only the low vCount bits select a glyph row
  assign unusedVcount = ^bus.vCount[COUNT_W-1:ROW_W];

  // Hold the last fetch address and tag the following cycle with the fetch's blank flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      highQ <= '0;
      lowQ  <= '0;
      tagQ  <= '0;
    end else begin
      tagQ <= '{valid: fetch, blank: bus.charCode[CODE_W-1]};
      if (fetch) begin
        highQ <= bus.charCode;
        lowQ  <= nextRow;
      end
    end
  end

  // ROM strobe and address: live during the fetch cycle so the ROM captures them
  // with the strobe, held afterwards; all forced low while reset is asserted.
  always_comb begin
    bus.romEnable      = 1'b0;
    bus.highAddrOffset = highQ;
    bus.lowAddrOffset  = lowQ;
    if (fetch && !reset) begin
      bus.romEnable      = 1'b1;
      bus.highAddrOffset = bus.charCode;
      bus.lowAddrOffset  = nextRow;
    end
  end

  // Blank glyphs and fetches lost to reset load an empty cell, never stale ROM data
  always_comb begin
    loadData = '0;
    if (tagQ.valid && !tagQ.blank) begin
      loadData = bus.romByte;
    end
  end

  pixel_shifter u_shifter (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .loadData (loadData),
    .pixelBit (shiftBit)
  );

  assign bus.pixelOut = shiftBit & bus.videoOn;

endmodule
